alu_muldiv_unit: RTL and testbench

Parametrised, multi-cycle multiply/divide unit with HI/LO registers. It extends the datapath's funct-field ALU decode to the R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO group. It sits beside the single-cycle ALU in the execute stage. The control unit issues an operation with a one-cycle `start` strobe, stalls on `busy`, and reads HI/LO back through `result`.

---
 rtl/alu_muldiv_unit_if.sv | 27 ++
 rtl/alu_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// rtl/alu_muldiv_unit_if.sv - command/result bundle between the control unit and the mul/div unit
//   master : drives start, funct, opA, opB; observes busy, done, illegal, hi, lo, result
//   slave  : the mul/div unit itself (opposite directions)
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct, opA, opB,
    input  busy, done, illegal, hi, lo, result
  );

  modport slave (
    input  start, funct, opA, opB,
    output busy, done, illegal, hi, lo, result
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU with HI/LO and MFHI/MTHI/MFLO/MTLO
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of alu_muldiv_unit_if
//             start/funct/opA/opB in; busy/done/illegal pulses, hi/lo registers,
//             result = hi (MFHI) / lo (MFLO) / 0 combinationally
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     b_q, b_d;          // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d; // negate product / quotient in FIX
  logic                 neg_hi_q, neg_hi_d; // negate remainder in FIX
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 illegal_q, illegal_d;

  // Operand magnitudes for the signed forms; unsigned forms pass through.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign a_neg     = is_signed & bus.opA[WIDTH-1];
  assign b_neg     = is_signed & bus.opB[WIDTH-1];
  assign a_abs     = a_neg ? -bus.opA : bus.opA;
  assign b_abs     = b_neg ? -bus.opB : bus.opB;

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right; the carry
  // out of the add becomes the new top bit.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: shift {rem, quo} left, trial-subtract the divisor
  // from the widened remainder, keep the difference only if it did not borrow.
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_step;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   quo_neg, rem_neg;
  assign acc_neg = -acc_q;
  assign quo_neg = -acc_q[WIDTH-1:0];
  assign rem_neg = -acc_q[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.funct)
            F_MULT, F_MULTU: state_d = S_CALC;
            F_DIV, F_DIVU:   state_d = (bus.opB == '0) ? S_DONE : S_CALC;
            default:         state_d = S_IDLE;
          endcase
        end
      end
      S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.funct)
            F_MTHI: hi_d = bus.opA;
            F_MTLO: lo_d = bus.opA;
            F_MFHI, F_MFLO: ;
            F_MULT, F_MULTU: begin
              acc_d    = {{WIDTH{1'b0}}, b_abs};
              b_d      = a_abs;
              is_div_d = 1'b0;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg ^ b_neg;
              cnt_d    = '0;
            end
            F_DIV, F_DIVU: begin
              if (bus.opB == '0) begin
                hi_d = bus.opA;
                lo_d = '1;
              end else begin
                acc_d    = {{WIDTH{1'b0}}, a_abs};
                b_d      = b_abs;
                is_div_d = 1'b1;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;   // remainder follows the dividend
                cnt_d    = '0;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? quo_neg : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? acc_neg : acc_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy    = (state_q == S_CALC) || (state_q == S_FIX);
    bus.done    = (state_q == S_DONE);
    bus.illegal = illegal_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
    case (bus.funct)
      F_MFHI:  bus.result = hi_q;
      F_MFLO:  bus.result = lo_q;
      default: bus.result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - directed checks of alu_muldiv_unit at WIDTH=32 and WIDTH=8
module tb_alu_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(32)) bus32 ();
  alu_muldiv_unit_if #(.WIDTH(8))  bus8 ();

  alu_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1; bus32.funct = f; bus32.opA = a; bus32.opB = b;
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1; bus8.funct = f; bus8.opA = a; bus8.opB = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // Called just after the start edge E0; n = edges from E0 until done seen.
  // b0 = busy right after E0, bw = busy right after E0+wid.
  task automatic wait_done(input bit w8, input int wid, output int n,
                           output logic b0, output logic bw);
    n  = 0;
    b0 = w8 ? bus8.busy : bus32.busy;
    bw = 1'b0;
    while (!(w8 ? bus8.done : bus32.done) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == wid) bw = w8 ? bus8.busy : bus32.busy;
    end
  endtask

  int   n;
  logic b0, bw;

  initial begin
    bus32.start = 0; bus32.funct = 0; bus32.opA = 0; bus32.opB = 0;
    bus8.start  = 0; bus8.funct  = 0; bus8.opA  = 0; bus8.opB  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", bus32.hi, 0);
    check("rst_lo", bus32.lo, 0);
    check("rst_busy", bus32.busy, 0);
    check("rst_done", bus32.done, 0);
    check("rst_illegal", bus32.illegal, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI / MFHI, MTLO
    issue32(6'h11, 32'h1234, 0);
    check("mthi_busy", bus32.busy, 0);
    check("mthi_done", bus32.done, 0);
    bus32.funct = 6'h10;
    #1 check("mfhi_result", bus32.result, 32'h1234);
    issue32(6'h13, 32'hBEEF, 0);
    check("mtlo_lo", bus32.lo, 32'hBEEF);
    bus32.funct = 6'h12;
    #1 check("mflo_result", bus32.result, 32'hBEEF);

    // Reset in the middle of a MULT
    issue32(6'h18, 32'd5, 32'd7);
    repeat (5) @(posedge clk);
    #1 check("mid_busy", bus32.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", bus32.hi, 0);
    check("arst_lo", bus32.lo, 0);
    check("arst_busy", bus32.busy, 0);
    check("arst_done", bus32.done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue32(6'h19, 32'd3, 32'd5);
    wait_done(0, 32, n, b0, bw);
    check("multu3x5_lo", bus32.lo, 15);
    check("multu3x5_hi", bus32.hi, 0);
    @(posedge clk); #1;

    // MULTU full-scale with timing
    issue32(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 32, n, b0, bw);
    check("multu_ff_edges", n, 33);
    check("multu_ff_busy_e0", b0, 1);
    check("multu_ff_busy_ew", bw, 1);
    check("multu_ff_busy_done", bus32.busy, 0);
    check("multu_ff_hi", bus32.hi, 32'hFFFFFFFE);
    check("multu_ff_lo", bus32.lo, 32'h00000001);
    @(posedge clk); #1;
    check("multu_ff_done_pulse", bus32.done, 0);

    issue32(6'h18, -32'sd7, 32'd3);
    wait_done(0, 32, n, b0, bw);
    check("mult_m7x3_hi", bus32.hi, 32'hFFFFFFFF);
    check("mult_m7x3_lo", bus32.lo, 32'hFFFFFFEB);
    @(posedge clk); #1;

    issue32(6'h1A, -32'sd7, 32'd2);
    wait_done(0, 32, n, b0, bw);
    check("div_m7d2_edges", n, 33);
    check("div_m7d2_lo", bus32.lo, 32'hFFFFFFFD);
    check("div_m7d2_hi", bus32.hi, 32'hFFFFFFFF);
    @(posedge clk); #1;

    issue32(6'h1B, 32'd100, 32'd7);
    wait_done(0, 32, n, b0, bw);
    check("divu_100d7_lo", bus32.lo, 14);
    check("divu_100d7_hi", bus32.hi, 2);
    @(posedge clk); #1;

    issue32(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, 32, n, b0, bw);
    check("div_min_lo", bus32.lo, 32'h80000000);
    check("div_min_hi", bus32.hi, 0);
    @(posedge clk); #1;

    // Divide by zero
    issue32(6'h1B, 32'd5, 32'd0);
    check("dz_done", bus32.done, 1);
    check("dz_busy", bus32.busy, 0);
    check("dz_lo", bus32.lo, 32'hFFFFFFFF);
    check("dz_hi", bus32.hi, 5);
    @(posedge clk); #1;
    check("dz_done_end", bus32.done, 0);
    check("dz_busy_end", bus32.busy, 0);

    // MTLO while busy is dropped
    issue32(6'h19, 32'd2, 32'd3);
    issue32(6'h13, 32'hDEAD, 0);
    check("mtlo_busy_lo", bus32.lo, 32'hFFFFFFFF);
    wait_done(0, 31, n, b0, bw);
    check("mtlo_busy_edges", n, 32);
    check("mtlo_busy_final_lo", bus32.lo, 6);
    check("mtlo_busy_final_hi", bus32.hi, 0);
    @(posedge clk); #1;

    // Unsupported funct
    issue32(6'h20, 32'h55, 32'h66);
    check("ill_pulse", bus32.illegal, 1);
    check("ill_done", bus32.done, 0);
    check("ill_busy", bus32.busy, 0);
    @(posedge clk); #1;
    check("ill_pulse_end", bus32.illegal, 0);
    check("ill_hi", bus32.hi, 0);
    check("ill_lo", bus32.lo, 6);
    bus32.funct = 6'h12;
    #1 check("mflo_after", bus32.result, 6);
    bus32.funct = 6'h19;
    #1 check("result_other", bus32.result, 0);

    // WIDTH=8 instance
    @(posedge clk); #1;
    issue8(6'h19, 8'hFF, 8'hFF);
    wait_done(1, 8, n, b0, bw);
    check("w8_edges", n, 9);
    check("w8_busy_e0", b0, 1);
    check("w8_busy_ew", bw, 1);
    check("w8_hi", bus8.hi, 8'hFE);
    check("w8_lo", bus8.lo, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
